nl_output_vc_tracker: RTL
=========================

# nl_output_vc_tracker

Per-output-port, per-output-VC state and credit tracker that generates the `vc_status` free vector consumed by the unrestricted VC allocator.
- Sequences each downstream VC through allocate → forward → release.
- Counts downstream buffer credits and gates switch requests.
- Flags protocol violations.
- Sits beside the VC allocator in every router, one instance per router covering all `np` output ports.

## Interface
Parameters:
- `np`, 5: number of router ports.
- `nv`, 2: VCs per port.
- `buf_len`, 4: downstream flit buffer depth per VC (initial credits); ≥1.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `alloc`  in  [np-1:0][nv-1:0]  output VC [p][v] granted to a packet this cycle (OR of allocator grants per output VC).
- `flit_sent`  in  [np-1:0][nv-1:0]  a flit left on output VC [p][v] this cycle.
- `tail_sent`  in  [np-1:0][nv-1:0]  the flit sent this cycle is a tail; only meaningful with `flit_sent`.
- `credit_in`  in  [np-1:0][nv-1:0]  downstream returned one credit for VC [p][v].
- `vc_status`  out  [np-1:0][nv-1:0]  1 = VC free and allocatable (registered).
- `credit_ok`  out  [np-1:0][nv-1:0]  1 = credit count > 0 (registered).
- `error`  out  1  sticky protocol-violation flag; cleared only by reset.

## Operation
- Per VC: state ∈ {FREE, ACTIVE, DRAINING}; credit counter `cnt`, width $clog2(buf_len+1).
- Counter, evaluated every cycle:
  - `cnt_next = cnt - flit_sent + credit_in`.
  - Simultaneous send and credit leaves `cnt` unchanged.
  - `flit_sent` with `cnt==0` and no same-cycle `credit_in`: error set, counter held at 0 (no wrap).
  - `credit_in` that would take `cnt` above `buf_len`: error set, counter saturates at `buf_len`.
- FREE:
  - `alloc` → ACTIVE.
  - `flit_sent` while FREE → error, state unchanged, counter still updated.
- ACTIVE:
  - `flit_sent && tail_sent` → release, per Configuration.
  - `alloc` while ACTIVE or DRAINING → error, ignored.
- DRAINING: → FREE in the cycle `cnt_next == buf_len`.
- Same-cycle `alloc` and `tail_sent` on one FREE VC: alloc taken; tail is an error (flit on non-active VC).
- `vc_status = (state==FREE)`; `credit_ok = (cnt != 0)`.
- Reset mid-packet discards all state: every VC FREE, `cnt = buf_len`, `error = 0`.

## Timing
- Reset values: `vc_status` all 1; `credit_ok` all 1; `error` 0; `cnt` = `buf_len`; state FREE.
- `alloc` at cycle t → `vc_status[p][v]` = 0 from t+1.
- Tail sent at cycle t:
  - Non-atomic mode: `vc_status` = 1 at t+1.
  - Atomic mode: `vc_status` = 1 at t+1 if `cnt_next == buf_len` at t; otherwise DRAINING, and `vc_status` = 1 the cycle after the final credit arrives.
- `credit_ok` reflects `cnt` one cycle after the event; no combinational input-to-output paths.
- `error` rises the cycle after the violating input and stays high.

## Configuration
- `NL_VC_ATOMIC_REALLOC_EN` defined:
  - Tail from ACTIVE enters DRAINING, or goes FREE directly if credits are already full.
  - A VC is re-allocatable only when its downstream buffer is empty, so no two packets ever share a downstream VC buffer.
- Undefined:
  - Tail from ACTIVE → FREE at t+1 regardless of `cnt`.
  - DRAINING state is unreachable and may be optimized away; credits continue to be tracked independently.

## Test plan
- Reset, no stimulus → `vc_status` = all 1s, `credit_ok` = all 1s, `error` = 0, every `cnt` = 4 (`buf_len`=4).
- `alloc[1][0]` at t; 4 `flit_sent` at t+1..t+4, last with `tail_sent`; no credits:
  - `vc_status[1][0]` = 0 from t+1.
  - `credit_ok[1][0]` = 0 at t+5.
  - Non-atomic: `vc_status[1][0]` = 1 at t+5.
  - Atomic: `vc_status[1][0]` stays 0 until 4 credits return, then 1 the cycle after the 4th.
- `flit_sent` and `credit_in` together on [0][1] with `cnt`=2 → `cnt` stays 2, `credit_ok` = 1, no error.
- `flit_sent` on [2][1] with `cnt`=0 and no credit → `error` = 1 next cycle, `cnt` stays 0; also `credit_in` at `cnt`=4 → `error` = 1, `cnt` stays 4.
- `alloc[3][1]` while ACTIVE → `error` = 1, state and `vc_status` unchanged; `rst_n` = 0 for one cycle → all outputs return to reset values next cycle.
- Atomic mode: tail at t with the last outstanding credit also at t → `vc_status` = 1 at t+1, DRAINING never entered.

Source files
------------

// File: rtl/nl_output_vc_tracker_if.sv
// Per-output-VC control bundle between the VC allocator/switch side (master)
// and the output VC tracker (slave).
interface nl_output_vc_tracker_if #(
  parameter int np = 5,
  parameter int nv = 2
);
  logic [np-1:0][nv-1:0] alloc;
  logic [np-1:0][nv-1:0] flit_sent;
  logic [np-1:0][nv-1:0] tail_sent;
  logic [np-1:0][nv-1:0] credit_in;
  logic [np-1:0][nv-1:0] vc_status;
  logic [np-1:0][nv-1:0] credit_ok;
  logic                  error;

  modport master (
    output alloc, flit_sent, tail_sent, credit_in,
    input  vc_status, credit_ok, error
  );

  modport slave (
    input  alloc, flit_sent, tail_sent, credit_in,
    output vc_status, credit_ok, error
  );
endinterface

// File: rtl/nl_output_vc_tracker.sv
// Output VC state and credit tracker feeding the VC allocator's free vector.
// Define NL_VC_ATOMIC_REALLOC_EN to hold a released VC until its downstream buffer drains.
module nl_output_vc_tracker #(
  parameter int np      = 5,
  parameter int nv      = 2,
  parameter int buf_len = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  nl_output_vc_tracker_if.slave   bus
);

  localparam int cw = $clog2(buf_len + 1);
  localparam logic [cw-1:0] full_c = cw'(buf_len);
  localparam logic [cw:0]   full_w = (cw + 1)'(buf_len);

  typedef enum logic [1:0] {
    FREE     = 2'd0,
    ACTIVE   = 2'd1,
    DRAINING = 2'd2
  } vc_state_e;

  vc_state_e             state   [np][nv];
  vc_state_e             st_nxt  [np][nv];
  logic [cw-1:0]         cnt     [np][nv];
  logic [cw-1:0]         cnt_nxt [np][nv];
  logic [cw:0]           sum     [np][nv];
  logic [np-1:0][nv-1:0] vs_nxt;
  logic [np-1:0][nv-1:0] ok_nxt;
  logic                  err_any;

  always_comb begin
    // NOTE: every comb output gets a default before the loop so no path leaves it unassigned (no latch).
    err_any = 1'b0;
    vs_nxt  = '0;
    ok_nxt  = '0;
    for (int p = 0; p < np; p++) begin
      for (int v = 0; v < nv; v++) begin
        st_nxt[p][v]  = state[p][v];
        cnt_nxt[p][v] = cnt[p][v];
        // One guard bit so an over-return is visible before saturation.
        sum[p][v] = {1'b0, cnt[p][v]} + {{cw{1'b0}}, bus.credit_in[p][v]};

        if (bus.flit_sent[p][v]) begin
          if (sum[p][v] == '0) begin
            err_any       = 1'b1;
            cnt_nxt[p][v] = '0;
          end else begin
            cnt_nxt[p][v] = cw'(sum[p][v] - 1'b1);
          end
        end else if (sum[p][v] > full_w) begin
          err_any       = 1'b1;
          cnt_nxt[p][v] = full_c;
        end else begin
          cnt_nxt[p][v] = cw'(sum[p][v]);
        end

        case (state[p][v])
          FREE: begin
            if (bus.alloc[p][v])     st_nxt[p][v] = ACTIVE;
            if (bus.flit_sent[p][v]) err_any = 1'b1;
          end
          ACTIVE: begin
            if (bus.alloc[p][v]) err_any = 1'b1;
            if (bus.flit_sent[p][v] && bus.tail_sent[p][v]) begin
`ifdef NL_VC_ATOMIC_REALLOC_EN
              st_nxt[p][v] = (cnt_nxt[p][v] == full_c) ? FREE : DRAINING;
`else
              st_nxt[p][v] = FREE;
`endif
            end
          end
          DRAINING: begin
            // The packet has already left; any further flit or grant here is a protocol slip.
            if (bus.alloc[p][v] || bus.flit_sent[p][v]) err_any = 1'b1;
            if (cnt_nxt[p][v] == full_c) st_nxt[p][v] = FREE;
          end
          default: st_nxt[p][v] = FREE;
        endcase

        vs_nxt[p][v] = (st_nxt[p][v] == FREE);
        ok_nxt[p][v] = (cnt_nxt[p][v] != '0);
      end
    end
  end

  // NOTE: state and counters are plain per-VC flops, not a RAM, so all of them are reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < np; p++) begin
        for (int v = 0; v < nv; v++) begin
          state[p][v] <= FREE;
          cnt[p][v]   <= full_c;
        end
      end
      bus.vc_status <= '1;
      bus.credit_ok <= '1;
      bus.error     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      for (int p = 0; p < np; p++) begin
        for (int v = 0; v < nv; v++) begin
          state[p][v] <= st_nxt[p][v];
          cnt[p][v]   <= cnt_nxt[p][v];
        end
      end
      bus.vc_status <= vs_nxt;
      bus.credit_ok <= ok_nxt;
      bus.error     <= bus.error | err_any;
    end
  end

endmodule
